// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: controller state
// encoding and default bus/memory geometry.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_WORDS_DEF = 128;
    localparam int TIMEOUT_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_busy_timer.sv
// Busy-wait watchdog for the memory controller. Counts consecutive busy
// cycles spent in ISSUE and flags expiry on the cycle whose edge would be the
// TIMEOUT_CYCLES-th busy one. Only instantiated when MEMCTRL_TIMEOUT_EN is set.
module mem_busy_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic issue_i,
    input  logic busy_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count busy edges while issuing; any other state clears the count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (!issue_i) begin
            cnt_q <= '0;
        end else if (busy_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = issue_i && busy_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side data-memory initiator. Takes one load/store from the MEM stage,
// drives the memory strobes under busy back-pressure, captures the registered
// read data and returns a one-cycle response (with range error and flush).
// Optional build macro: MEMCTRL_TIMEOUT_EN adds a busy-wait timeout that
// aborts the access into an error response after TIMEOUT_CYCLES busy cycles.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MEM_WORDS      = MEM_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_busy
);

    // One extra bit so the compare never wraps whatever MEM_WORDS is.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    state_t state_q, state_d;

    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              flush_pending_q, flush_pending_d;

    logic accept;
    logic in_range;
    logic timeout;
    logic suppress;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < ADDR_LIMIT);
    // A flush seen on the completing edge still counts against this response.
    assign suppress  = flush_pending_q || flush;

`ifdef MEMCTRL_TIMEOUT_EN
    mem_busy_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_busy_timer (
        .clk       (clk),
        .nreset    (nreset),
        .issue_i   (state_q == ST_ISSUE),
        .busy_i    (mem_busy),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_range ? ST_ISSUE : ST_ERROR;
                end
            end
            ST_ISSUE: begin
                if (timeout) begin
                    state_d = ST_ERROR;
                end else if (!mem_busy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            ST_ERROR:   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs.
    always_comb begin
        mem_we_d        = mem_we_q;
        mem_re_d        = mem_re_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        resp_valid_d    = 1'b0;
        resp_data_d     = resp_data_q;
        resp_err_d      = resp_err_q;
        flush_pending_d = flush_pending_q;
        case (state_q)
            ST_IDLE: begin
                flush_pending_d = 1'b0;
                mem_we_d        = 1'b0;
                mem_re_d        = 1'b0;
                if (accept && in_range) begin
                    mem_we_d   = req_we;
                    mem_re_d   = !req_we;
                    mem_addr_d = req_addr;
                    mem_data_d = req_wdata;
                end
            end
            ST_ISSUE: begin
                flush_pending_d = flush_pending_q || flush;
                if (timeout || !mem_busy) begin
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                resp_valid_d    = !suppress;
                resp_data_d     = mem_q;
                resp_err_d      = 1'b0;
                flush_pending_d = 1'b0;
            end
            ST_ERROR: begin
                resp_valid_d    = !suppress;
                resp_data_d     = '0;
                resp_err_d      = 1'b1;
                flush_pending_d = 1'b0;
            end
            default: begin
                mem_we_d = 1'b0;
                mem_re_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_we_q        <= 1'b0;
            mem_re_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            mem_we_q        <= mem_we_d;
            mem_re_q        <= mem_re_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_err_q      <= resp_err_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a 128-word registered-read memory
// responder on the bus side, and a transaction-level reference (word array,
// latency and flush rules) predicting every response.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        flush;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] mem_addr, mem_data, mem_q;
    logic        mem_we, mem_re, mem_busy;

    logic        pl_we;
    logic [6:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] bus_mem [0:127];
    logic [31:0] ref_mem [0:127];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_data   (mem_data),
        .mem_q      (mem_q),
        .mem_busy   (mem_busy)
    );

    // Memory responder: registered read, write echoes data on q, stalls on busy.
    always @(posedge clk) begin
        if (pl_we) begin
            bus_mem[pl_addr] <= pl_data;
        end else if (!mem_busy) begin
            if (mem_we) begin
                bus_mem[mem_addr[6:0]] <= mem_data;
                mem_q <= mem_data;
            end else if (mem_re) begin
                mem_q <= bus_mem[mem_addr[6:0]];
            end
        end
    end

    // One request, called just after a negedge; returns at the negedge of the
    // response cycle (where a new request may be presented immediately).
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int nbusy, input int flush_cyc, input string tag);
        bit          inr, tmo, sup, got;
        int          exp_strobes, exp_cyc, nstrobe, first_strobe;
        logic        exp_err;
        logic [31:0] exp_data;
        inr = (addr < 32'd128);
        tmo = 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
        tmo = inr && (nbusy >= 16);
`endif
        exp_strobes = !inr ? 0 : (tmo ? 16 : 1 + nbusy);
        exp_cyc     = !inr ? 2 : (tmo ? 18 : 3 + nbusy);
        exp_err     = !inr || tmo;
        exp_data    = exp_err ? 32'h0 : (we ? wdata : ref_mem[addr[6:0]]);
        if (inr && !tmo && we) ref_mem[addr[6:0]] = wdata;
        sup = (flush_cyc >= 1);
        got = 1'b0;
        nstrobe = 0;
        first_strobe = 0;

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        flush = (flush_cyc == 0);
        mem_busy = 1'b0;
        nchk++;
        if (req_ready !== 1'b1) begin
            nerr++; $display("FAIL %s req_ready_at_accept: got %b expected 1", tag, req_ready);
        end
        @(posedge clk);
        for (int j = 1; j <= exp_cyc; j++) begin
            @(negedge clk);
            if (mem_re === 1'b1 || mem_we === 1'b1) begin
                nstrobe++;
                if (first_strobe == 0) first_strobe = j;
                nchk++;
                if (mem_we !== we || mem_re !== !we || mem_addr !== addr ||
                    (we && mem_data !== wdata)) begin
                    nerr++;
                    $display("FAIL %s strobe_cyc%0d: got we=%b re=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             tag, j, mem_we, mem_re, mem_addr, mem_data, we, addr, wdata);
                end
            end
            nchk++;
            if (req_ready !== (j == exp_cyc)) begin
                nerr++; $display("FAIL %s req_ready_cyc%0d: got %b expected %b", tag, j, req_ready, j == exp_cyc);
            end
            if (resp_valid !== 1'b0) begin
                nchk++;
                if (j != exp_cyc || sup) begin
                    nerr++; $display("FAIL %s resp_valid_cyc%0d: got 1 expected 0", tag, j);
                end else begin
                    got = 1'b1;
                    if (resp_data !== exp_data || resp_err !== exp_err) begin
                        nerr++;
                        $display("FAIL %s resp: got data=%h err=%b expected data=%h err=%b",
                                 tag, resp_data, resp_err, exp_data, exp_err);
                    end
                end
            end
            if (j < exp_cyc) begin
                // Garbage on the request side must be ignored outside IDLE.
                req_valid = 1'($urandom); req_we = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
                mem_busy = (j <= nbusy);
                flush = (j == flush_cyc);
            end else begin
                req_valid = 1'b0; mem_busy = 1'b0; flush = 1'b0;
            end
        end
        nchk++;
        if (got !== !sup) begin
            nerr++; $display("FAIL %s resp_seen: got %b expected %b", tag, got, !sup);
        end
        nchk++;
        if (nstrobe != exp_strobes || (exp_strobes > 0 && first_strobe != 1)) begin
            nerr++; $display("FAIL %s strobe_count: got %0d (first cyc %0d) expected %0d (first cyc 1)",
                             tag, nstrobe, first_strobe, exp_strobes);
        end
    endtask

    task automatic test_reset();
        nchk++;
        if (mem_we !== 0 || mem_re !== 0 || mem_addr !== 0 || mem_data !== 0 ||
            resp_valid !== 0 || resp_data !== 0 || resp_err !== 0 || req_ready !== 1) begin
            nerr++;
            $display("FAIL reset_outputs: got we=%b re=%b addr=%h data=%h rv=%b rd=%h re=%b rdy=%b expected all 0, ready 1",
                     mem_we, mem_re, mem_addr, mem_data, resp_valid, resp_data, resp_err, req_ready);
        end
    endtask

    task automatic test_load();
        do_req(1'b0, 32'd5, 32'h0, 0, -1, "load5");
    endtask

    task automatic test_store_load();
        do_req(1'b1, 32'd127, 32'h0000_1234, 0, -1, "store127");
        do_req(1'b0, 32'd127, 32'h0, 0, -1, "load127");
    endtask

    task automatic test_busy_stretch();
        do_req(1'b0, 32'd5, 32'h0, 3, -1, "busy3");
        do_req(1'b1, 32'd64, 32'hA5A5_0001, 2, -1, "busy2_st");
        do_req(1'b0, 32'd64, 32'h0, 1, -1, "busy1_ld");
    endtask

    task automatic test_out_of_range();
        do_req(1'b0, 32'd128, 32'h0, 0, -1, "oor128");
        do_req(1'b0, 32'hFFFF_FFFF, 32'h0, 0, -1, "oorFFFF");
        do_req(1'b1, 32'h8000_0000, 32'h1111_2222, 0, -1, "oor_store");
    endtask

    task automatic test_flush();
        do_req(1'b1, 32'd3, 32'hCAFE_F00D, 1, 1, "flush_store");
        do_req(1'b0, 32'd3, 32'h0, 0, -1, "flush_readback");
        do_req(1'b0, 32'd3, 32'h0, 0, 0, "flush_on_accept");
        do_req(1'b0, 32'd200, 32'h0, 0, 1, "flush_error");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic        we;
            logic [31:0] addr;
            int          nb, fc, ec, r;
            we = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      addr = 32'd128 + ($urandom % 1000);
            else if (r == 1) addr = 32'hFFFF_FFFF - ($urandom % 4);
            else             addr = $urandom_range(0, 127);
            nb = $urandom_range(0, 3);
            ec = (addr < 32'd128) ? 3 + nb : 2;
            r = $urandom_range(0, 7);
            if (r == 0)      fc = 0;
            else if (r == 1) fc = $urandom_range(1, ec - 1);
            else             fc = -1;
            do_req(we, addr, $urandom, nb, fc, $sformatf("rand%0d", n));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_issue();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd10; flush = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0; mem_busy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        nchk++;
        if (mem_re !== 1'b1) begin
            nerr++; $display("FAIL midreset_held_strobe: got mem_re=%b expected 1", mem_re);
        end
        nreset = 1'b0;
        #1;
        nchk++;
        if (mem_re !== 0 || mem_we !== 0 || mem_addr !== 0 || req_ready !== 1 || resp_valid !== 0) begin
            nerr++;
            $display("FAIL midreset_async: got re=%b we=%b addr=%h rdy=%b rv=%b expected 0 0 0 1 0",
                     mem_re, mem_we, mem_addr, req_ready, resp_valid);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        nreset = 1'b1;
        @(negedge clk);
    endtask

`ifdef MEMCTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_req(1'b0, 32'd20, 32'h0, 30, -1, "timeout_ld");
        do_req(1'b1, 32'd21, 32'h7777_7777, 30, -1, "timeout_st");
        do_req(1'b0, 32'd21, 32'h0, 0, -1, "timeout_readback");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_busy = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            pl_we = 1'b1;
            pl_addr = 7'(i);
            pl_data = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        test_reset();
        nreset = 1'b1;
        @(negedge clk);
        test_load();
        test_store_load();
        test_busy_stretch();
        test_out_of_range();
        test_flush();
        test_back_to_back();
        test_reset_mid_issue();
        test_load();
`ifdef MEMCTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
